// File: rtl/fp_pkg.sv
// Floating-point format helpers shared by the multiplier pipeline: field widths,
// bias, operand class encoding, flag bit positions and the canonical NaN.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;
  localparam int FLAGS_W = 4;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_sig_width(input int man_w);
    return man_w + 1;
  endfunction

  function automatic int fp_prod_width(input int man_w);
    return 2 * (man_w + 1);
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, mantissa MSB set; caller keeps the low bits.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_man_mult.sv
// Unsigned significand multiplier, combinational (0 cycles); no flow control.
// Isolated so it can later be swapped for a multi-cycle implementation.
module fp_man_mult #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined FP multiplier, 3-cycle latency, 1/cycle; valid/ready stall holds all stages (up to 3 buffered).
// FP_MULT_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p,
  output logic [TAG_W-1:0]       out_tag,
  output logic [FLAGS_W-1:0]     out_flags
);

  localparam int W    = fp_width(EXP_W, MAN_W);
  localparam int SW   = fp_sig_width(MAN_W);
  localparam int PW   = fp_prod_width(MAN_W);
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic [63:0]      CNAN_ALL = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]     CNAN     = CNAN_ALL[W-1:0];
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [MAN_W-1:0]   ma;
    logic [MAN_W-1:0]   mb;
    fp_class_e          ca;
    fp_class_e          cb;
    logic [TAG_W-1:0]   tag;
  } s1_t;

  typedef struct packed {
    logic               sign;
    logic [XW-1:0]      exp;
    logic [PW-1:0]      prod;
    logic               spec;
    logic               spec_nv;
    logic [W-1:0]       spec_p;
    logic [TAG_W-1:0]   tag;
  } s2_t;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (e == EXP_ONES) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic s1_vld, s2_vld, s3_vld;
  logic ld1, ld2, ld3;

  // A stage loads when empty or when its successor is loading, so bubbles collapse.
  assign ld3       = !s3_vld || out_ready;
  assign ld2       = !s2_vld || ld3;
  assign ld1       = !s1_vld || ld2;
  assign in_ready  = ld1;
  assign out_valid = s3_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      if (ld1) s1_vld <= in_valid;
      if (ld2) s2_vld <= s1_vld;
      if (ld3) s3_vld <= s2_vld;
    end
  end

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_a[W-1] ^ in_b[W-1];
    s1_d.ea   = in_a[W-2 -: EXP_W];
    s1_d.eb   = in_b[W-2 -: EXP_W];
    s1_d.ma   = in_a[MAN_W-1:0];
    s1_d.mb   = in_b[MAN_W-1:0];
    s1_d.ca   = classify(in_a[W-2 -: EXP_W], in_a[MAN_W-1:0]);
    s1_d.cb   = classify(in_b[W-2 -: EXP_W], in_b[MAN_W-1:0]);
    s1_d.tag  = in_tag;
  end

  logic [PW-1:0] prod;

  fp_man_mult #(.W(SW)) u_man_mult (
    .a ({1'b1, s1_q.ma}),
    .b ({1'b1, s1_q.mb}),
    .p (prod)
  );

  // Exponent kept as two's complement in XW bits so under/overflow stay visible.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.exp  = {2'b00, s1_q.ea} + {2'b00, s1_q.eb} - XW'(BIAS);
    s2_d.prod = prod;
    s2_d.tag  = s1_q.tag;
    if (s1_q.ca == CLS_NAN || s1_q.cb == CLS_NAN) begin
      s2_d.spec   = 1'b1;
      s2_d.spec_p = CNAN;
    end else if ((s1_q.ca == CLS_INF && s1_q.cb == CLS_ZERO) ||
                 (s1_q.ca == CLS_ZERO && s1_q.cb == CLS_INF)) begin
      s2_d.spec    = 1'b1;
      s2_d.spec_nv = 1'b1;
      s2_d.spec_p  = CNAN;
    end else if (s1_q.ca == CLS_INF || s1_q.cb == CLS_INF) begin
      s2_d.spec   = 1'b1;
      s2_d.spec_p = {s1_q.sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s1_q.ca == CLS_ZERO || s1_q.cb == CLS_ZERO) begin
      s2_d.spec   = 1'b1;
      s2_d.spec_p = {s1_q.sign, {(W-1){1'b0}}};
    end
  end

  logic               norm;
  logic [PW-2:0]      nprod;
  logic [MAN_W-1:0]   man_t;
  logic [MAN_W-1:0]   man_f;
  logic               guard, sticky, rnd_c;
  logic [XW-1:0]      exp_f;
  logic               ovf, unf;
  logic [W-1:0]       res_p;
  logic [FLAGS_W-1:0] res_flags;

  // Align the hidden bit to the top; the hidden bit itself is dropped here.
  assign norm   = s2_q.prod[PW-1];
  assign nprod  = norm ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
  assign man_t  = nprod[PW-2 -: MAN_W];
  assign guard  = nprod[MAN_W];
  assign sticky = |nprod[MAN_W-1:0];

`ifdef FP_MULT_RNE_EN
  logic [MAN_W:0] man_r;
  assign man_r = {1'b0, man_t} + {{MAN_W{1'b0}}, guard & (sticky | man_t[0])};
  assign man_f = man_r[MAN_W-1:0];
  assign rnd_c = man_r[MAN_W];
`else
  assign man_f = man_t;
  assign rnd_c = 1'b0;
`endif

  assign exp_f = s2_q.exp + XW'(norm) + XW'(rnd_c);
  assign ovf   = $signed(exp_f) >= $signed({2'b00, EXP_ONES});
  assign unf   = exp_f[XW-1] || (exp_f == '0);

  always_comb begin
    res_p              = {s2_q.sign, exp_f[EXP_W-1:0], man_f};
    res_flags          = '0;
    res_flags[FLAG_NX] = guard | sticky;
    if (s2_q.spec) begin
      res_p              = s2_q.spec_p;
      res_flags          = '0;
      res_flags[FLAG_NV] = s2_q.spec_nv;
    end else if (ovf) begin
      res_p              = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      res_flags[FLAG_OF] = 1'b1;
      res_flags[FLAG_NX] = 1'b1;
    end else if (unf) begin
      res_p              = {s2_q.sign, {(W-1){1'b0}}};
      res_flags[FLAG_UF] = 1'b1;
      res_flags[FLAG_NX] = 1'b1;
    end
  end

  // Payload registers move only on an advance carrying a valid op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      out_p     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else begin
      if (ld1 && in_valid) s1_q <= s1_d;
      if (ld2 && s1_vld)   s2_q <= s2_d;
      if (ld3 && s2_vld) begin
        out_p     <= res_p;
        out_tag   <= s2_q.tag;
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (bfloat16 defaults): directed values, backpressure,
// mid-stream reset. Expected results are queued at acceptance and compared at the output.
module tb_fp_mult_pipe;

  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  flags;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pcyc   = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

`ifdef FP_MULT_RNE_EN
  localparam logic [15:0] RND_TIE   = 16'h3FC2;
  localparam logic [15:0] RND_CARRY = 16'h4000;
`else
  localparam logic [15:0] RND_TIE   = 16'h3FC1;
  localparam logic [15:0] RND_CARRY = 16'h3FFF;
`endif

  logic [15:0] va [NV];
  logic [15:0] vb [NV];
  logic [15:0] vp [NV];
  logic [3:0]  vf [NV];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                      input logic [15:0] ep, input logic [3:0] ef, input bit lat, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else if (push) sb.push_back('{p: ep, flags: ef, tag: tag, acc: pcyc, lat: lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: head of queue must be presented (and held during stalls).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          check("stray_valid", 32'(out_valid), 32'd0);
        end else begin
          check("tag", 32'(out_tag), 32'(sb[0].tag));
          check("p", 32'(out_p), 32'(sb[0].p));
          check("flags", 32'(out_flags), 32'(sb[0].flags));
          if (out_ready) begin
            if (sb[0].lat) check("latency", 32'(pcyc - sb[0].acc), 32'd3);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    va = '{16'h3FC0, 16'hC000, 16'h3F81, 16'h3F81, 16'h7F80, 16'h7F80, 16'h7FC1, 16'h0001, 16'h7F00,
           16'h0080, 16'h3FB5, 16'h2000, 16'h2000, 16'h7F00, 16'h0000, 16'h8080, 16'hFF80, 16'h8000};
    vb = '{16'h3FC0, 16'h4040, 16'h3FC0, 16'h3F81, 16'h0000, 16'hBF80, 16'h3F80, 16'h3F80, 16'h4000,
           16'h0080, 16'h3FB5, 16'h1F80, 16'h2000, 16'h3F80, 16'hFF80, 16'h0080, 16'hFF80, 16'h3F80};
    vp = '{16'h4010, 16'hC0C0, RND_TIE, 16'h3F82, 16'h7FC0, 16'hFF80, 16'h7FC0, 16'h0000, 16'h7F80,
           16'h0000, RND_CARRY, 16'h0000, 16'h0080, 16'h7F00, 16'h7FC0, 16'h8000, 16'h7F80, 16'h8000};
    vf = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h5,
           4'h3, 4'h1, 4'h3, 4'h0, 4'h0, 4'h8, 4'h3, 4'h0, 4'h0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed values, back to back, no stall: latency checked on each.
    for (int i = 0; i < NV; i++) send(va[i], vb[i], 4'(i), vp[i], vf[i], 1'b1, 1'b1);
    drain();

    // Backpressure: 6 stalled cycles while 5 tagged ops stream in.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 5; t++)
          send(16'h3F80, 16'h4000 + 16'(t * 16), 4'(t), 16'h4000 + 16'(t * 16), 4'h0, 1'b0, 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        check("in_ready_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: none of them may surface afterwards.
    @(posedge clk);
    #1;
    for (int t = 0; t < 3; t++) send(16'h3F80, 16'h3F80, 4'(5 + t), 16'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_p", 32'(out_p), 32'd0);
    check("arst_out_tag", 32'(out_tag), 32'd0);
    check("arst_out_flags", 32'(out_flags), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    send(16'h4040, 16'h3F80, 4'h9, 16'h4040, 4'h0, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined floating-point multiplier; the next generation of the team's single-cycle bfloat16 multiplier. Supports any EXP_W/MAN_W format and adds a valid/ready handshake, special-value handling, IEEE-style flags and round-to-nearest-even. Sits between the CNN operand fetch stage and the accumulator, one product per cycle.

## Interface
- EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 7, stored mantissa width (hidden bit implied)
- TAG_W, 4, sideband tag carried alongside each operation
- clk  in  1  clock, rising edge
- rst  in  1  reset; **asynchronous, active-high**
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts the pair this cycle
- in_a, in_b  in  1+EXP_W+MAN_W  operands: {sign, exp, man}
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  1+EXP_W+MAN_W  product
- out_tag  out  TAG_W  tag of this product
- out_flags  out  4  {nv, of, uf, nx}: invalid, overflow, underflow, inexact

## Operation
- Transfer occurs on a cycle with valid & ready high on the same port.
- Classify each operand: zero (exp==0; subnormals are flushed to zero), inf (exp all ones, man 0), NaN (exp all ones, man≠0), normal.
- Sign = sa ^ sb on every path except NaN.
- Normal path: the product of {1,ma}×{1,mb} is 2·(MAN_W+1) bits. If the MSB is set, shift right 1 and add 1 to the exponent. Biased exponent = ea + eb − bias + norm, computed in EXP_W+2 signed bits.
- Rounding: guard = first dropped bit; sticky = OR of the remaining dropped bits. Mantissa carry-out after rounding renormalises (exp+1, man=0).
- Overflow (exp ≥ all-ones): ±inf, of=1, nx=1.
- Underflow (exp ≤ 0): ±0, uf=1, nx=1.
- NaN input, or inf×0: canonical NaN = {0, all-ones, 1 followed by zeros}, nv=1 for inf×0 only. inf×normal/inf gives ±inf with no flags. 0×normal gives ±0.
- nx=1 whenever any dropped bit is non-zero.

## Timing
- Three register stages: S1 operand/classify, S2 mantissa product + exponent sum, S3 normalise/round/pack. The S3 register drives all outputs.
- Latency: 3 cycles from accepting transfer to out_valid, with no stall.
- Throughput: 1 per cycle while out_ready is high.
- Per-stage valid bit. A stage loads when it is empty or its successor is loading. in_ready = S1 empty or S1 advancing. in_ready may depend combinationally on out_ready; no other combinational in→out paths.
- Stall: with out_ready low, outputs and all full stages hold stable. Bubbles collapse, so up to 3 results are buffered. Order is strictly preserved.
- Reset (any time, including mid-stream): all valid bits clear immediately; out_valid=0, out_p=0, out_tag=0, out_flags=0. In-flight operations are discarded. in_ready is 1 after reset deassert.
- Data registers load only on stage advance; no data changes while out_valid & !out_ready.

## Configuration
- FP_MULT_RNE_EN defined: round-to-nearest-even. Round up if guard & (sticky | lsb).
- Not defined: truncation toward zero. Guard/sticky still drive nx, and the rounding incrementer is removed.

## Structure
- Package fp_pkg: format-field width functions, bias constant, class encoding typedef (ZERO/NORM/INF/NAN), flag bit index constants, canonical NaN constant function.
- Sub-module fp_man_mult: unsigned (MAN_W+1)×(MAN_W+1) mantissa multiplier, instantiated in S2. This is the retiming point for a future multi-cycle multiplier.

## Test plan
- Defaults, no stall: 0x3FC0×0x3FC0 → 0x4010; 0x4000×0x4040 → 0xC0C0 when in_a=0xC000; flags 0, out_valid exactly 3 cycles after acceptance.
- Rounding: 0x3F81×0x3FC0 → 0x3FC2, nx=1 with FP_MULT_RNE_EN; 0x3FC1, nx=1 without. 0x3F81×0x3F81 → 0x3F82, nx=1 in both builds.
- Specials: 0x7F80×0x0000 → 0x7FC0, nv=1; 0x7F80×0xBF80 → 0xFF80, flags 0; 0x7FC1×0x3F80 → 0x7FC0, nv=0; 0x0001×0x3F80 → 0x0000.
- Range: 0x7F00×0x4000 → 0x7F80, of=1, nx=1; 0x0080×0x0080 → 0x0000, uf=1, nx=1.
- Backpressure: out_ready low for 6 cycles while streaming 5 tagged ops. in_ready drops after 3 are held. After release, tags emerge 0,1,2,3,4 in order with no loss or duplication, and outputs are stable during the stall.
- Reset mid-stream: assert rst with 3 ops in flight. All outputs go to 0 asynchronously, no stale result appears after release, and the next op completes in 3 cycles.
